// File: rtl/char_buffer_writer_if.sv
// Byte-stream handshake plus grid/cursor outputs between a character feeder and char_buffer_writer.
// The writer sits on the slave side; the feeder (UART RX or sequencer) drives the master side.
interface char_buffer_writer_if #(
    parameter int NUM_CELLS = 20
);
    localparam int CW = $clog2(NUM_CELLS);

    logic [7:0]                  i_byte;
    logic                        i_byte_dv;
    logic                        o_ready;
    logic                        i_clear;
    logic [NUM_CELLS-1:0][7:0]   o_characters;
    logic [CW-1:0]               o_cursor;
    logic                        o_update;
    logic                        o_busy;

    modport master (
        output i_byte, i_byte_dv, i_clear,
        input  o_ready, o_characters, o_cursor, o_update, o_busy
    );

    modport slave (
        input  i_byte, i_byte_dv, i_clear,
        output o_ready, o_characters, o_cursor, o_update, o_busy
    );
endinterface

// File: rtl/char_buffer_writer.sv
// Interprets a byte stream into a ROWS x COLUMNS character grid with cursor; clear and scroll
// are sequenced one cell per cycle with back-pressure while they run.
module char_buffer_writer #(
    parameter int         COLUMNS    = 10,
    parameter int         ROWS       = 2,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    char_buffer_writer_if.slave  bus
);
    localparam int NUM_CELLS = COLUMNS * ROWS;
    localparam int CW        = $clog2(NUM_CELLS);
    localparam int IW        = CW + 1;

    localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_CELLS - 1);
    localparam logic [IW-1:0] IDX_COPY_END = IW'(NUM_CELLS - COLUMNS);
    localparam logic [CW-1:0] CUR_LAST     = CW'(NUM_CELLS - 1);
    localparam logic [CW-1:0] LAST_ROW     = CW'((ROWS - 1) * COLUMNS);
    localparam logic [CW-1:0] COLS_C       = CW'(COLUMNS);

    typedef enum logic [1:0] {IDLE, CLEAR, SCROLL} state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic [CW-1:0]   cursor_reg, cursor_next;
    logic [CW-1:0]   target_reg, target_next;
    logic            pending_reg, pending_next;
    logic            update_reg, update_next;
    logic            busy_reg;
    logic [7:0]      cells_reg [NUM_CELLS];

    logic            wr_en;
    logic [CW-1:0]   wr_addr;
    logic [7:0]      wr_data;
    logic            accept;
    logic [CW-1:0]   col;
    logic [CW-1:0]   src_addr;

    assign bus.o_ready  = (state_reg == IDLE) && !pending_reg && !bus.i_clear;
    assign accept       = bus.o_ready && bus.i_byte_dv;
    assign col          = cursor_reg % COLS_C;
    // Only used while idx is below the copy boundary, so it never exceeds the last cell.
    assign src_addr     = idx_reg[CW-1:0] + COLS_C;

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        cursor_next  = cursor_reg;
        target_next  = target_reg;
        pending_next = pending_reg | bus.i_clear;
        update_next  = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = cursor_reg;
        wr_data      = BLANK_CHAR;

        unique case (state_reg)
            IDLE: begin
                if (pending_reg) begin
                    state_next   = CLEAR;
                    idx_next     = '0;
                    pending_next = bus.i_clear;
                end else if (accept) begin
                    if (bus.i_byte >= 8'h20 && bus.i_byte <= 8'h7E) begin
                        wr_en   = 1'b1;
                        wr_data = bus.i_byte;
                        if (cursor_reg == CUR_LAST) begin
                            state_next  = SCROLL;
                            idx_next    = '0;
                            target_next = LAST_ROW;
                        end else begin
                            cursor_next = cursor_reg + 1'b1;
                            update_next = 1'b1;
                        end
                    end else begin
                        case (bus.i_byte)
                            8'h08: if (cursor_reg != '0) begin
                                cursor_next = cursor_reg - 1'b1;
                                wr_en       = 1'b1;
                                wr_addr     = cursor_reg - 1'b1;
                                update_next = 1'b1;
                            end
                            8'h0D: cursor_next = cursor_reg - col;
                            8'h0A: begin
                                if (cursor_reg < LAST_ROW) begin
                                    cursor_next = cursor_reg + COLS_C;
                                end else begin
                                    // On the last row the column is kept, so the target is the cursor itself.
                                    state_next  = SCROLL;
                                    idx_next    = '0;
                                    target_next = cursor_reg;
                                end
                            end
                            8'h0C: begin
                                state_next = CLEAR;
                                idx_next   = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            CLEAR: begin
                wr_en    = 1'b1;
                wr_addr  = idx_reg[CW-1:0];
                idx_next = idx_reg + 1'b1;
                if (idx_reg == IDX_LAST) begin
                    cursor_next = '0;
                    state_next  = IDLE;
                    update_next = 1'b1;
                end
            end
            SCROLL: begin
                wr_en    = 1'b1;
                wr_addr  = idx_reg[CW-1:0];
                wr_data  = (idx_reg < IDX_COPY_END) ? cells_reg[src_addr] : BLANK_CHAR;
                idx_next = idx_reg + 1'b1;
                if (idx_reg == IDX_LAST) begin
                    cursor_next = target_reg;
                    state_next  = IDLE;
                    update_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            cursor_reg  <= '0;
            target_reg  <= '0;
            pending_reg <= 1'b0;
            update_reg  <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            cursor_reg  <= cursor_next;
            target_reg  <= target_next;
            pending_reg <= pending_next;
            update_reg  <= update_next;
            busy_reg    <= (state_next != IDLE);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NUM_CELLS; i++) cells_reg[i] <= BLANK_CHAR;
        end else if (wr_en) begin
            cells_reg[wr_addr] <= wr_data;
        end
    end

    // Cell 0 lands in the most significant byte, like an SV string literal.
    for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_pack
        assign bus.o_characters[NUM_CELLS-1-gi] = cells_reg[gi];
    end

    assign bus.o_cursor = cursor_reg;
    assign bus.o_update = update_reg;
    assign bus.o_busy   = busy_reg;
endmodule

// File: tb/tb_char_buffer_writer.sv
// Directed and randomized checks of char_buffer_writer against a row/column grid model.
module tb_char_buffer_writer;
    localparam int COLS = 10;
    localparam int ROWS = 2;
    localparam int NC   = COLS * ROWS;
    localparam int VW   = 8 * NC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    char_buffer_writer_if #(.NUM_CELLS(NC)) vif ();

    char_buffer_writer #(.COLUMNS(COLS), .ROWS(ROWS), .BLANK_CHAR(8'h20)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (vif.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int upd_cnt = 0;
    int busy_cnt = 0;
    int rdy_low_cnt = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (vif.o_update) upd_cnt++;
            if (vif.o_busy) busy_cnt++;
            if (!vif.o_ready) rdy_low_cnt++;
        end
    end

    logic [7:0] m_cells [NC];
    int         m_cursor;

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NC; k++) m_cells[k] = 8'h20;
        m_cursor = 0;
    endfunction

    function automatic void model_scroll();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                m_cells[r*COLS + c] = (r < ROWS-1) ? m_cells[(r+1)*COLS + c] : 8'h20;
    endfunction

    function automatic void model_apply(input logic [7:0] b, output int upd, output int busy);
        int row;
        upd = 0;
        busy = 0;
        row = m_cursor / COLS;
        if (b >= 8'h20 && b <= 8'h7E) begin
            m_cells[m_cursor] = b;
            upd = 1;
            if (m_cursor < NC-1) m_cursor++;
            else begin model_scroll(); m_cursor = (ROWS-1)*COLS; busy = NC; end
        end else if (b == 8'h08) begin
            if (m_cursor > 0) begin m_cursor--; m_cells[m_cursor] = 8'h20; upd = 1; end
        end else if (b == 8'h0D) begin
            m_cursor = row * COLS;
        end else if (b == 8'h0A) begin
            if (row < ROWS-1) m_cursor += COLS;
            else begin model_scroll(); busy = NC; upd = 1; end
        end else if (b == 8'h0C) begin
            model_reset();
            busy = NC;
            upd = 1;
        end
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < NC; k++) v[8*(NC-1-k) +: 8] = m_cells[k];
        return v;
    endfunction

    task automatic check_grid(input string tag);
        check({tag, "_grid"}, vif.o_characters, model_vec());
        check({tag, "_cursor"}, VW'(vif.o_cursor), VW'(m_cursor));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        vif.i_byte_dv = 1'b0;
        vif.i_clear = 1'b0;
        vif.i_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        int n = 0;
        while (vif.o_busy && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) check("settle_timeout", VW'(n), VW'(0));
        @(posedge clk);
        #1;
    endtask

    // Presents one byte, waits for o_ready, lets it be accepted, updates the model.
    task automatic send(input logic [7:0] b, output int upd, output int busy);
        int n = 0;
        vif.i_byte = b;
        vif.i_byte_dv = 1'b1;
        while (!vif.o_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) check("ready_timeout", VW'(n), VW'(0));
        @(posedge clk);
        #1;
        vif.i_byte_dv = 1'b0;
        model_apply(b, upd, busy);
    endtask

    task automatic send_and_check(input logic [7:0] b, input string tag);
        int u0, b0, eu, eb;
        u0 = upd_cnt;
        b0 = busy_cnt;
        send(b, eu, eb);
        settle();
        check_grid(tag);
        check({tag, "_update"}, VW'(upd_cnt - u0), VW'(eu));
        check({tag, "_busy"}, VW'(busy_cnt - b0), VW'(eb));
    endtask

    task automatic stream(input string s, output int eu, output int eb);
        int u, b;
        eu = 0;
        eb = 0;
        for (int i = 0; i < s.len(); i++) begin
            vif.i_byte = s[i];
            vif.i_byte_dv = 1'b1;
            @(posedge clk);
            #1;
            model_apply(s[i], u, b);
            eu += u;
            eb += b;
        end
        vif.i_byte_dv = 1'b0;
    endtask

    task automatic clear_pulse(input string tag);
        int u0, b0;
        u0 = upd_cnt;
        b0 = busy_cnt;
        vif.i_clear = 1'b1;
        @(posedge clk);
        #1;
        vif.i_clear = 1'b0;
        check({tag, "_pend_ready"}, VW'(vif.o_ready), VW'(0));
        @(posedge clk);
        #1;
        model_reset();
        settle();
        check_grid(tag);
        check({tag, "_update"}, VW'(upd_cnt - u0), VW'(1));
        check({tag, "_busy"}, VW'(busy_cnt - b0), VW'(NC));
    endtask

    initial begin
        int u0, b0, r0, eu, eb;
        logic [7:0] b;
        logic [VW-1:0] exp_v;

        vif.i_byte = 8'h00;
        vif.i_byte_dv = 1'b0;
        vif.i_clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_grid", vif.o_characters, {NC{8'h20}});
        check("rst_cursor", VW'(vif.o_cursor), VW'(0));
        check("rst_ready", VW'(vif.o_ready), VW'(1));
        check("rst_update", VW'(vif.o_update), VW'(0));
        check("rst_busy", VW'(vif.o_busy), VW'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back stream without wrap
        u0 = upd_cnt; r0 = rdy_low_cnt;
        stream("Hello, world!", eu, eb);
        settle();
        exp_v = {"Hello, world!", "       "};
        check("hello_grid", vif.o_characters, exp_v);
        check("hello_model", vif.o_characters, model_vec());
        check("hello_cursor", VW'(vif.o_cursor), VW'(13));
        check("hello_update", VW'(upd_cnt - u0), VW'(13));
        check("hello_ready_low", VW'(rdy_low_cnt - r0), VW'(0));

        // Fill the whole grid; the 20th write triggers a scroll
        do_reset();
        u0 = upd_cnt; b0 = busy_cnt; r0 = rdy_low_cnt;
        stream("ABCDEFGHIJKLMNOPQRST", eu, eb);
        settle();
        exp_v = {"KLMNOPQRST", "          "};
        check("fill_grid", vif.o_characters, exp_v);
        check("fill_cursor", VW'(vif.o_cursor), VW'(10));
        check("fill_ready_low", VW'(rdy_low_cnt - r0), VW'(20));
        check("fill_busy", VW'(busy_cnt - b0), VW'(20));
        check("fill_update", VW'(upd_cnt - u0), VW'(19 + 1));

        // Backspace
        do_reset();
        send_and_check("H", "bs_h");
        send_and_check("i", "bs_i");
        send_and_check(8'h08, "bs_del");
        check("bs_cell1", VW'(vif.o_characters[NC-2]), VW'(8'h20));
        send_and_check(8'h08, "bs_del2");
        send_and_check(8'h08, "bs_at0");

        // CR/LF then scroll via LF on the last row
        do_reset();
        send_and_check("a", "crlf_a");
        send_and_check("b", "crlf_b");
        send_and_check(8'h0D, "crlf_cr");
        send_and_check(8'h0A, "crlf_lf");
        send_and_check("c", "crlf_c");
        check("crlf_cell10", VW'(vif.o_characters[NC-1-10]), VW'("c"));
        send_and_check("d", "lf_d");
        send_and_check("e", "lf_e");
        send_and_check("f", "lf_f");
        send_and_check(8'h0A, "lf_scroll");
        check("lf_cells0_3", VW'(vif.o_characters[NC-1 -: 4]), VW'("cdef"));
        check("lf_cursor14", VW'(vif.o_cursor), VW'(14));

        // Clear pulse collides with a pending byte
        u0 = upd_cnt; b0 = busy_cnt;
        vif.i_byte = "X";
        vif.i_byte_dv = 1'b1;
        vif.i_clear = 1'b1;
        @(posedge clk);
        #1;
        vif.i_clear = 1'b0;
        check("clrx_ready_low", VW'(vif.o_ready), VW'(0));
        model_reset();
        begin
            int n = 0;
            while (!vif.o_ready && n < 200) begin @(posedge clk); #1; n++; end
            if (n >= 200) check("clrx_timeout", VW'(n), VW'(0));
        end
        check("clrx_blank", vif.o_characters, {NC{8'h20}});
        @(posedge clk);
        #1;
        vif.i_byte_dv = 1'b0;
        model_apply("X", eu, eb);
        settle();
        check_grid("clrx");
        check("clrx_cell0", VW'(vif.o_characters[NC-1]), VW'("X"));
        check("clrx_busy", VW'(busy_cnt - b0), VW'(20));
        check("clrx_update", VW'(upd_cnt - u0), VW'(2));

        // Form feed
        send_and_check(8'h0C, "ff");

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            int r;
            r = $urandom_range(0, 15);
            if (r <= 8) b = 8'($urandom_range(32, 126));
            else if (r == 9) b = 8'h08;
            else if (r == 10) b = 8'h0D;
            else if (r <= 12) b = 8'h0A;
            else if (r == 13) b = 8'h0C;
            else b = 8'($urandom_range(0, 31));
            if (r == 15) clear_pulse("rnd_clr");
            else send_and_check(b, "rnd");
        end

        // Reset in the middle of a scroll aborts it
        do_reset();
        stream("ABCDEFGHIJKLMNOPQRST", eu, eb);
        repeat (5) @(posedge clk);
        #1;
        check("midscroll_busy", VW'(vif.o_busy), VW'(1));
        rst_n = 1'b0;
        #1;
        check("abort_grid", vif.o_characters, {NC{8'h20}});
        check("abort_cursor", VW'(vif.o_cursor), VW'(0));
        check("abort_ready", VW'(vif.o_ready), VW'(1));
        check("abort_update", VW'(vif.o_update), VW'(0));
        check("abort_busy", VW'(vif.o_busy), VW'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/char_buffer_writer.md
Name: char_buffer_writer

Overview:
Upstream feeder for the text overlay stage. It accepts a byte stream (UART RX or a test sequencer) over a valid/ready handshake and interprets the printable and control characters. It maintains a ROWS x COLUMNS character grid with a cursor, and drives the packed character array that the overlay consumes on its i_characters input. Clearing and scrolling are multi-cycle sequenced operations, and back-pressure is applied while they run.

Parameters:
COLUMNS, 10, characters per row; must match the overlay's COLUMNS.
ROWS, 2, character rows.
BLANK_CHAR, 8'h20, fill value used for clear, scroll and backspace.
NUM_CELLS (localparam), COLUMNS*ROWS, total cells; must match the overlay's NUM_CHAR.

Ports:
i_clk  in  1  pixel/system clock
i_reset_n  in  1  asynchronous, active-low reset
i_byte  in  8  input character code
i_byte_dv  in  1  i_byte valid
o_ready  out  1  block can accept a byte this cycle
i_clear  in  1  single-cycle clear request pulse
o_characters  out  NUM_CELLS*8 (packed [NUM_CELLS-1:0][7:0])  grid contents; cell 0 (top-left) is in the MSB byte [NUM_CELLS-1], cell k is in byte [NUM_CELLS-1-k], matching SV string-literal packing
o_cursor  out  $clog2(NUM_CELLS)  index of the next write cell
o_update  out  1  one-cycle pulse: grid contents changed
o_busy  out  1  CLEAR or SCROLL in progress

Behaviour:
- Reset (async assert, sync release): all cells = BLANK_CHAR; o_cursor=0; state IDLE; clear_pending=0; o_update=0; o_busy=0. Reset asserted mid-CLEAR or mid-SCROLL aborts the operation immediately.
- States: IDLE, CLEAR, SCROLL. Index counter idx is $clog2(NUM_CELLS)+1 bits wide.
- o_ready = (state==IDLE) && !clear_pending && !i_clear. A byte is accepted on a rising edge where i_byte_dv && o_ready.
- i_clear pulse in any state sets clear_pending. In IDLE, a pending clear wins over a simultaneous byte; that byte is not accepted. IDLE with clear_pending -> CLEAR, idx=0, and clear_pending is cleared.
- Accepted byte in IDLE:
  - Printable 0x20-0x7E: cell[cursor]<=byte; o_update pulses the next cycle. If cursor<NUM_CELLS-1, cursor++ and stay in IDLE; back-to-back accepts are allowed every cycle. If cursor==NUM_CELLS-1, -> SCROLL with target cursor (ROWS-1)*COLUMNS.
  - 0x08 BS: if cursor>0, cursor--, cell[cursor-1]<=BLANK_CHAR, o_update pulses. If cursor==0, no change and no pulse.
  - 0x0D CR: cursor<=cursor-(cursor mod COLUMNS); no o_update.
  - 0x0A LF: if row<ROWS-1, cursor+=COLUMNS. On the last row, -> SCROLL and the cursor column is kept.
  - 0x0C FF: -> CLEAR, identical to i_clear.
  - Any other code is consumed and ignored.
- CLEAR: one cell per cycle, cell[idx]<=BLANK_CHAR, idx++. After the cell NUM_CELLS-1 write: cursor<=0, -> IDLE, o_update pulses one cycle. Duration is exactly NUM_CELLS cycles with o_ready low.
- SCROLL: one cell per cycle. For idx<NUM_CELLS-COLUMNS, cell[idx]<=cell[idx+COLUMNS]; otherwise BLANK_CHAR. Duration is exactly NUM_CELLS cycles, then cursor<=target, -> IDLE, and a single o_update pulse (no pulse for the triggering write).
- o_busy = (state!=IDLE). All outputs except o_ready are registered.
- ROWS==1: SCROLL yields an all-blank grid, and the target cursor is 0 (or the kept column for LF).

Test Plan:
- Reset: hold i_reset_n=0 -> o_characters all 8'h20, o_cursor=0, o_ready=1, o_update=0; reassert i_reset_n=0 mid-SCROLL -> same values immediately.
- Stream "Hello, world!" (13 bytes) on consecutive cycles -> o_ready stays 1, o_characters equals the string packing of "Hello, world!" plus 7 blanks, o_cursor=13, 13 o_update pulses.
- Stream 'A'..'T' (20 bytes) -> after the 20th accept, o_ready=0 for exactly 20 cycles; then cells 0-9='K'..'T', cells 10-19=8'h20, o_cursor=10, one o_update pulse.
- Send "Hi",0x08 -> cell1=8'h20, o_cursor=1. Send 0x08 at cursor 0 -> no change, no o_update.
- Send "ab",0x0D,0x0A,"c" -> cell10='c', o_cursor=11. Send "def",0x0A -> SCROLL, then cells 0-3="cdef", o_cursor=14.
- i_clear pulse on the same cycle as i_byte_dv with 'X' held -> 'X' not accepted, 20 CLEAR cycles, grid blank, o_cursor=0; the following cycle 'X' is accepted into cell 0.
